// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and defaults for the instruction fetch queue.
// Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
    logic                  filled;
  } fetch_slot_t;

endpackage
`default_nettype wire

// File: rtl/fetch_slot_array.sv
`default_nettype none
// ============================================================================
// Module   : fetch_slot_array
// Purpose  : Slot storage {pc, instr, filled} with allocate/fill/retire/clear.
// Revision : 1.0  initial release
// ============================================================================
module fetch_slot_array #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int IW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  alloc_i,
  input  logic [IW-1:0]         alloc_idx_i,
  input  logic [DATA_WIDTH-1:0] alloc_pc_i,
  input  logic                  fill_i,
  input  logic [IW-1:0]         fill_idx_i,
  input  logic [DATA_WIDTH-1:0] fill_data_i,
  input  logic                  retire_i,
  input  logic [IW-1:0]         head_idx_i,
  output logic [DATA_WIDTH-1:0] head_pc_o,
  output logic [DATA_WIDTH-1:0] head_instr_o,
  output logic                  head_filled_o
);

  logic [DATA_WIDTH-1:0] pc_q    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_q [DEPTH];
  logic [DEPTH-1:0]      filled_q;

  // Allocate, fill and retire never target the same slot in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        pc_q[s]    <= '0;
        instr_q[s] <= '0;
      end
      filled_q <= '0;
    end else if (clear_i) begin
      for (int s = 0; s < DEPTH; s++) begin
        pc_q[s]    <= '0;
        instr_q[s] <= '0;
      end
      filled_q <= '0;
    end else begin
      if (alloc_i) begin
        pc_q[alloc_idx_i]     <= alloc_pc_i;
        instr_q[alloc_idx_i]  <= '0;
        filled_q[alloc_idx_i] <= 1'b0;
      end
      if (fill_i) begin
        instr_q[fill_idx_i]  <= fill_data_i;
        filled_q[fill_idx_i] <= 1'b1;
      end
      if (retire_i) begin
        filled_q[head_idx_i] <= 1'b0;
      end
    end
  end

  assign head_pc_o     = pc_q[head_idx_i];
  assign head_instr_o  = instr_q[head_idx_i];
  assign head_filled_o = filled_q[head_idx_i];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : In-order instruction fetch queue with flush/drain of responses.
// Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
  parameter int DATA_WIDTH = fetch_pkg::DATA_WIDTH,
  parameter int DEPTH      = fetch_pkg::DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc_in,
  output logic                  pc_adv,
  output logic                  req_valid,
  output logic [DATA_WIDTH-1:0] req_addr,
  input  logic                  req_ready,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  flush,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [DATA_WIDTH-1:0] if_pc,
  input  logic                  id_ready
);
  import fetch_pkg::*;

  localparam int            IW   = $clog2(DEPTH);
  localparam int            CW   = IW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [IW-1:0] head_q, head_d, tail_q, tail_d, fillp_q, fillp_d;
  logic [CW-1:0] occ_q, occ_d, pend_q, pend_d, drop_q, drop_d;

  logic                  w_accept, w_rsp_any, w_fill, w_retire, w_head_filled;
  logic [CW-1:0]         w_inflight;
  logic [DATA_WIDTH-1:0] w_head_pc, w_head_instr;

  // pend counts live (slot-backed) requests, drop counts orphaned ones; at
  // most one of them is nonzero, so their sum never exceeds DEPTH.
  assign w_inflight = pend_q + drop_q;
  assign w_rsp_any  = rsp_valid && (w_inflight != '0);
  assign w_fill     = w_rsp_any && (drop_q == '0) && !flush;
  assign w_accept   = req_valid && req_ready;
  assign w_retire   = if_valid && id_ready;

  assign pc_adv   = w_accept;
  assign req_addr = pc_in;
  assign if_valid = w_head_filled && !flush;
  assign if_pc    = w_head_pc;
  assign if_instr = w_head_instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)                                 state_d = (drop_d != '0) ? DRAIN : RUN;
    else if (state_q == DRAIN && drop_q == '0) state_d = RUN;
  end

  always_comb begin
    req_valid = 1'b0;
    if (!rst && !flush && state_q == RUN && occ_q < FULL) req_valid = 1'b1;
  end

  always_comb begin
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      fillp_d = '0;
      occ_d   = '0;
      pend_d  = '0;
      drop_d  = w_inflight - CW'(w_rsp_any);
    end else begin
      head_d  = head_q + IW'(w_retire);
      tail_d  = tail_q + IW'(w_accept);
      fillp_d = fillp_q + IW'(w_fill);
      occ_d   = occ_q + CW'(w_accept) - CW'(w_retire);
      pend_d  = pend_q + CW'(w_accept) - CW'(w_fill);
      drop_d  = drop_q - CW'(w_rsp_any && (drop_q != '0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      fillp_q <= '0;
      occ_q   <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      fillp_q <= fillp_d;
      occ_q   <= occ_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  fetch_slot_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_slots (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (flush),
    .alloc_i       (w_accept),
    .alloc_idx_i   (tail_q),
    .alloc_pc_i    (pc_in),
    .fill_i        (w_fill),
    .fill_idx_i    (fillp_q),
    .fill_data_i   (rsp_data),
    .retire_i      (w_retire),
    .head_idx_i    (head_q),
    .head_pc_o     (w_head_pc),
    .head_instr_o  (w_head_instr),
    .head_filled_o (w_head_filled)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Directed and randomized checks of fetch_queue against a queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, pc_adv, req_valid, req_ready, rsp_valid, flush, if_valid, id_ready;
  logic [DW-1:0] pc_in, req_addr, rsp_data, if_instr, if_pc;

  fetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_adv(pc_adv), .req_valid(req_valid),
    .req_addr(req_addr), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .flush(flush), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] addr; int due; } mreq_t;

  fetch_slot_t   q[$];
  mreq_t         mq[$];
  int            live_m, drop_m;
  bit            drain_m;
  logic [DW-1:0] pc_m, redir_pc;
  int            cyc, lat_min, lat_max;
  int            n_checks, n_fail;
  int            acc_cnt, ret_cnt, ifv_cnt, rsp_cnt;
  logic [DW-1:0] ret_pcs[$];
  logic          last_rv;

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [DW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DW-1:0] ret_at(input int i);
    return (ret_pcs.size() > i) ? ret_pcs[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_obs();
    acc_cnt = 0; ret_cnt = 0; ifv_cnt = 0; rsp_cnt = 0;
    ret_pcs.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; req_ready = 1'b0; id_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0; pc_in = '0;
    #1;
    check_eq("rst_if_valid", if_valid, 1'b0);
    check_eq("rst_req_valid", req_valid, 1'b0);
    q.delete(); mq.delete();
    live_m = 0; drop_m = 0; drain_m = 1'b0; pc_m = '0; cyc = 0;
    @(negedge clk);
    check_eq("rst_if_pc", if_pc, '0);
    check_eq("rst_if_instr", if_instr, '0);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic fl, input logic rr, input logic ir);
    logic          rsp_v, exp_rv, exp_iv, rsp_eff;
    logic [DW-1:0] rsp_d;
    fetch_slot_t   s;
    @(negedge clk);
    rsp_v = (mq.size() > 0) && (mq[0].due <= cyc);
    rsp_d = rsp_v ? mem_word(mq[0].addr) : '0;
    flush = fl; req_ready = rr; id_ready = ir; pc_in = pc_m;
    rsp_valid = rsp_v; rsp_data = rsp_d;
    #2;
    exp_rv = !drain_m && (q.size() < DEPTH) && !fl;
    exp_iv = (q.size() > 0) && q[0].filled && !fl;
    check_eq("req_valid", req_valid, exp_rv);
    check_eq("pc_adv", pc_adv, exp_rv & rr);
    if (exp_rv) check_eq("req_addr", req_addr, pc_m);
    check_eq("if_valid", if_valid, exp_iv);
    if (exp_iv) begin
      check_eq("if_pc", if_pc, q[0].pc);
      check_eq("if_instr", if_instr, q[0].instr);
    end
    if (rsp_v) check_eq("rsp_has_outstanding", (live_m + drop_m) > 0, 1'b1);

    acc_cnt += int'(pc_adv);
    ifv_cnt += int'(if_valid);
    rsp_cnt += int'(rsp_v);
    last_rv = req_valid;
    if (if_valid && ir) begin
      ret_cnt++;
      ret_pcs.push_back(if_pc);
    end

    rsp_eff = rsp_v && ((live_m + drop_m) > 0);
    if (fl) begin
      drop_m  = live_m + drop_m - (rsp_eff ? 1 : 0);
      live_m  = 0;
      drain_m = (drop_m != 0);
      q.delete();
      pc_m = redir_pc;
    end else begin
      if (drain_m && drop_m == 0) drain_m = 1'b0;
      if (rsp_eff) begin
        if (drop_m > 0) drop_m--;
        else begin
          for (int i = 0; i < q.size(); i++) begin
            if (!q[i].filled) begin
              s = q[i]; s.filled = 1'b1; s.instr = rsp_d; q[i] = s;
              break;
            end
          end
          live_m--;
        end
      end
      if (exp_iv && ir) q.delete(0);
      if (exp_rv && rr) begin
        s.pc = pc_m; s.instr = '0; s.filled = 1'b0;
        q.push_back(s);
        live_m++;
        pc_m += 4;
      end
    end

    if (rsp_v) void'(mq.pop_front());
    if (req_valid && rr) mq.push_back('{addr: req_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; req_ready = 1'b0; id_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0; pc_in = '0;
    n_checks = 0; n_fail = 0; redir_pc = 32'h100; lat_min = 1; lat_max = 1;
    apply_reset();

    // Streaming at 1-cycle memory: first if_valid two cycles after first request.
    clear_obs();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1);
    check_eq("stream_no_early_retire", ret_cnt, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    check_eq("stream_pc_adv_cnt", acc_cnt, 6);
    check_eq("stream_retire_cnt", ret_cnt, 4);
    check_eq("stream_pc0", ret_at(0), 32'h0);
    check_eq("stream_pc1", ret_at(1), 32'h4);
    check_eq("stream_pc2", ret_at(2), 32'h8);

    // Back-pressure from decode fills the queue, then drains in order.
    apply_reset(); clear_obs();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
    check_eq("full_accept_cnt", acc_cnt, 4);
    check_eq("full_req_valid_low", last_rv, 1'b0);
    clear_obs();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);
    check_eq("drain_retire_cnt", ret_cnt, 4);
    for (int i = 0; i < 4; i++) check_eq("drain_order", ret_at(i), 32'(4 * i));

    // Flush with three outstanding requests; three idle cycles before each response.
    apply_reset(); clear_obs(); lat_min = 4; lat_max = 4;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    check_eq("fl3_accept_cnt", acc_cnt, 3);
    redir_pc = 32'h100;
    step(1'b1, 1'b0, 1'b1);
    clear_obs();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    check_eq("fl3_dropped_rsp", rsp_cnt, 3);
    check_eq("fl3_no_if_valid", ifv_cnt, 0);
    check_eq("fl3_no_req_in_drain", acc_cnt, 0);
    clear_obs(); lat_min = 1; lat_max = 1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    check_eq("fl3_post_pc", ret_at(0), 32'h100);
    check_eq("fl3_post_accept_cnt", acc_cnt, 4);

    // Flush, response and dequeue in the same cycle with two outstanding.
    apply_reset(); clear_obs(); lat_min = 2; lat_max = 2;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    clear_obs();
    step(1'b1, 1'b0, 1'b1);
    check_eq("fl2_rsp_same_cycle", rsp_cnt, 1);
    check_eq("fl2_no_retire", ret_cnt, 0);
    check_eq("fl2_if_valid_low", ifv_cnt, 0);
    clear_obs();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    check_eq("fl2_one_dropped", rsp_cnt, 1);
    check_eq("fl2_resume_accepts", acc_cnt, 1);

    // Reset in the middle of traffic with filled slots, then normal restart.
    apply_reset(); clear_obs(); lat_min = 1; lat_max = 1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    apply_reset(); clear_obs();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    check_eq("rst_restart_pc", ret_at(0), 32'h0);
    check_eq("rst_restart_accepts", acc_cnt, 3);

    // Randomized traffic with varying memory latency and occasional redirects.
    apply_reset(); clear_obs(); lat_min = 1; lat_max = 3;
    for (int i = 0; i < 600; i++) begin
      redir_pc = $urandom & 32'h0000_FFFC;
      step($urandom_range(99, 0) < 5, $urandom_range(99, 0) < 75, $urandom_range(99, 0) < 70);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
